// File: rtl/aer_spike_arbiter.sv
// aer_spike_arbiter: timestamps single-cycle spikes per channel and serialises them as
// {channel_id, timestamp} AER words via round-robin grant. Define AER_DROP_CNT_EN for the drop counter.
module aer_spike_arbiter #(
  parameter int NUM_CH = 16,
  parameter int CH_W   = 4,
  parameter int TS_W   = 20
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 arb_en,
  input  logic [NUM_CH-1:0]    spike_in,
  output logic [CH_W+TS_W-1:0] aer_word,
  output logic                 aer_valid,
  input  logic                 aer_ready,
  output logic                 pending_any,
  output logic [15:0]          drop_count
);
  typedef enum logic {S_EMPTY, S_FULL} state_t;

  state_t                 state_reg, state_next;
  logic [TS_W-1:0]        cnt_reg;
  logic [NUM_CH-1:0]      pend_reg, pend_next, grant_vec;
  logic [NUM_CH*TS_W-1:0] ts_flat;
  logic [CH_W-1:0]        ptr_reg, grant_id;
  logic                   found, grant;
  logic [CH_W+TS_W-1:0]   word_reg;
  logic                   pany_reg;

  // First pending channel after the last winner, wrapping modulo NUM_CH.
  always_comb begin
    logic [CH_W-1:0] idx;
    found    = 1'b0;
    grant_id = '0;
    idx      = '0;
    for (int off = 1; off <= NUM_CH; off++) begin
      idx = ptr_reg + CH_W'(off);
      if (!found && pend_reg[idx]) begin
        found    = 1'b1;
        grant_id = idx;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    grant      = 1'b0;
    case (state_reg)
      S_EMPTY: begin
        if (arb_en && found) begin
          grant      = 1'b1;
          state_next = S_FULL;
        end
      end
      S_FULL: begin
        if (aer_ready) begin
          if (arb_en && found) grant = 1'b1;
          else state_next = S_EMPTY;
        end
      end
    endcase
  end

  always_comb begin
    grant_vec = '0;
    if (grant) grant_vec[grant_id] = 1'b1;
  end

  // A granted channel frees its slot in the same cycle, so a coincident spike is kept.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic            take;
    logic [TS_W-1:0] ts_reg;
    assign take           = spike_in[gi] & (~pend_reg[gi] | grant_vec[gi]);
    assign pend_next[gi]  = spike_in[gi] | (pend_reg[gi] & ~grant_vec[gi]);
    assign ts_flat[gi*TS_W +: TS_W] = ts_reg;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ts_reg <= '0;
      else if (take) ts_reg <= cnt_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_EMPTY;
      cnt_reg   <= '0;
      pend_reg  <= '0;
      ptr_reg   <= CH_W'(NUM_CH - 1);
      word_reg  <= '0;
      pany_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_reg + TS_W'(1);
      pend_reg  <= pend_next;
      pany_reg  <= |pend_reg;
      if (grant) begin
        ptr_reg  <= grant_id;
        word_reg <= {grant_id, ts_flat[grant_id*TS_W +: TS_W]};
      end
    end
  end

  assign aer_word    = word_reg;
  assign aer_valid   = (state_reg == S_FULL);
  assign pending_any = pany_reg;

`ifdef AER_DROP_CNT_EN
  logic [15:0]   drop_cnt_reg;
  logic [CH_W:0] drop_num;
  logic [16:0]   drop_sum;

  always_comb begin
    drop_num = '0;
    for (int i = 0; i < NUM_CH; i++)
      drop_num = drop_num + (CH_W+1)'(spike_in[i] & pend_reg[i] & ~grant_vec[i]);
    drop_sum = {1'b0, drop_cnt_reg} + 17'(drop_num);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_cnt_reg <= '0;
    else drop_cnt_reg <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  assign drop_count = drop_cnt_reg;
`else
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_aer_spike_arbiter.sv
// Bench for aer_spike_arbiter: directed table and sequences, then random traffic
// against an event-level reference model. A small-timestamp instance exercises wrap.
module tb_aer_spike_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        arb_en = 1'b0;
  logic        aer_ready = 1'b0;
  logic [15:0] spike_in = '0;
  logic [23:0] aer_word;
  logic        aer_valid, pending_any;
  logic [15:0] drop_count;

  logic        w_rst_n = 1'b0;
  logic [15:0] w_spike = '0;
  logic [7:0]  w_word;
  logic        w_valid, w_pany;
  logic [15:0] w_drop;

  always #5 clk = ~clk;

  aer_spike_arbiter dut (
    .clk(clk), .rst_n(rst_n), .arb_en(arb_en), .spike_in(spike_in),
    .aer_word(aer_word), .aer_valid(aer_valid), .aer_ready(aer_ready),
    .pending_any(pending_any), .drop_count(drop_count)
  );

  aer_spike_arbiter #(.NUM_CH(16), .CH_W(4), .TS_W(4)) dut_w (
    .clk(clk), .rst_n(w_rst_n), .arb_en(1'b1), .spike_in(w_spike),
    .aer_word(w_word), .aer_valid(w_valid), .aer_ready(1'b1),
    .pending_any(w_pany), .drop_count(w_drop)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int exp_drop1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: slots, stamps and a rotating pointer, updated once per clock.
  bit m_pend[16];
  int m_ts[16];
  int m_ptr = 15, m_cnt = 0, m_drop = 0, m_word = 0, m_gid;
  bit m_valid = 0, m_pany = 0, m_any, m_on = 0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin m_pend[i] = 0; m_ts[i] = 0; end
      m_ptr = 15; m_cnt = 0; m_drop = 0; m_word = 0; m_valid = 0; m_pany = 0;
    end else begin
      m_any = 0;
      for (int i = 0; i < 16; i++) m_any |= m_pend[i];
      if (arb_en && m_any && (!m_valid || aer_ready)) begin
        m_gid = -1;
        for (int j = 1; j <= 16; j++)
          if (m_gid < 0 && m_pend[(m_ptr + j) % 16]) m_gid = (m_ptr + j) % 16;
        m_word = m_gid * (1 << 20) + m_ts[m_gid];
        m_valid = 1; m_pend[m_gid] = 0; m_ptr = m_gid;
      end else if (m_valid && aer_ready) begin
        m_valid = 0;
      end
      for (int i = 0; i < 16; i++) begin
        if (spike_in[i]) begin
          if (m_pend[i]) begin
            if (m_drop < 65535) m_drop++;
          end else begin
            m_pend[i] = 1; m_ts[i] = m_cnt;
          end
        end
      end
      m_pany = m_any;
      m_cnt = (m_cnt + 1) % (1 << 20);
    end
  end

  initial forever begin
    int exp_drop;
    @(negedge clk);
`ifdef AER_DROP_CNT_EN
    exp_drop = m_drop;
`else
    exp_drop = 0;
`endif
    if (m_on && rst_n) begin
      chk("mdl_valid", 32'(aer_valid), 32'(m_valid));
      if (m_valid) chk("mdl_word", 32'(aer_word), m_word);
      chk("mdl_pending_any", 32'(pending_any), 32'(m_pany));
      chk("mdl_drop_count", 32'(drop_count), exp_drop);
    end
  end

  task automatic tick;
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; spike_in = '0; aer_ready = 1'b1; arb_en = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
  endtask

  typedef struct packed {
    logic [15:0] spike;
    logic        exp_valid;
    logic [23:0] exp_word;
    logic        exp_pany;
  } vec_t;
  vec_t tbl[10];

  initial begin
`ifdef AER_DROP_CNT_EN
    exp_drop1 = 1;
`else
    exp_drop1 = 0;
`endif
    for (int i = 0; i < 10; i++) tbl[i] = '{16'h0000, 1'b0, 24'h000000, 1'b0};
    tbl[5] = '{16'h0001, 1'b0, 24'h000000, 1'b0};
    tbl[7] = '{16'h0000, 1'b1, 24'h000005, 1'b1};

    // Reset values and single spike on ch0 at stamp 5
    do_reset();
    m_on = 1;
    chk("rst_word", 32'(aer_word), 0);
    chk("rst_valid", 32'(aer_valid), 0);
    chk("rst_pending_any", 32'(pending_any), 0);
    chk("rst_drop_count", 32'(drop_count), 0);
    for (int c = 0; c < 10; c++) begin
      spike_in = tbl[c].spike;
      chk($sformatf("t1_valid_c%0d", c), 32'(aer_valid), 32'(tbl[c].exp_valid));
      if (tbl[c].exp_valid) chk($sformatf("t1_word_c%0d", c), 32'(aer_word), 32'(tbl[c].exp_word));
      chk($sformatf("t1_pany_c%0d", c), 32'(pending_any), 32'(tbl[c].exp_pany));
      tick();
    end

    // All channels at once: ids 0..15 back-to-back with stamp 3
    do_reset();
    repeat (3) tick();
    spike_in = 16'hFFFF; tick();
    spike_in = '0;
    chk("t2_valid_c4", 32'(aer_valid), 0);
    tick();
    for (int n = 0; n < 16; n++) begin
      chk($sformatf("t2_valid_n%0d", n), 32'(aer_valid), 1);
      chk($sformatf("t2_word_n%0d", n), 32'(aer_word), (n << 20) | 3);
      tick();
    end
    chk("t2_valid_end", 32'(aer_valid), 0);

    // Backpressure: word held for 10 cycles, then next pending id follows
    do_reset();
    aer_ready = 1'b0;
    repeat (2) tick();
    spike_in = 16'h0005; tick();
    spike_in = '0; tick();
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("t3_hold_valid_%0d", i), 32'(aer_valid), 1);
      chk($sformatf("t3_hold_word_%0d", i), 32'(aer_word), 32'h000002);
      tick();
    end
    aer_ready = 1'b1;
    chk("t3_release_word", 32'(aer_word), 32'h000002);
    tick();
    chk("t3_next_valid", 32'(aer_valid), 1);
    chk("t3_next_word", 32'(aer_word), 32'h200002);
    tick();
    chk("t3_idle_valid", 32'(aer_valid), 0);

    // Second spike on a pending ch3 is dropped and keeps the first stamp
    do_reset();
    arb_en = 1'b0;
    repeat (2) tick();
    spike_in = 16'h0008; tick();
    spike_in = '0; tick();
    spike_in = 16'h0008; tick();
    spike_in = '0;
    chk("t4_drop_count", 32'(drop_count), exp_drop1);
    chk("t4_pany", 32'(pending_any), 1);
    tick();
    arb_en = 1'b1;
    chk("t4_no_grant_when_disabled", 32'(aer_valid), 0);
    tick();
    chk("t4_valid", 32'(aer_valid), 1);
    chk("t4_word", 32'(aer_word), 32'h300002);
    tick();
    chk("t4_idle_valid", 32'(aer_valid), 0);
    chk("t4_drop_final", 32'(drop_count), exp_drop1);

    // Timestamp wrap on the 4-bit instance: stamp F then spike on ch7 sees 0
    @(negedge clk);
    w_rst_n = 1'b1;
    repeat (16) @(negedge clk);
    w_spike = 16'h0080;
    @(negedge clk);
    w_spike = '0;
    chk("t5_valid_early", 32'(w_valid), 0);
    @(negedge clk);
    chk("t5_valid", 32'(w_valid), 1);
    chk("t5_word", 32'(w_word), 32'h70);
    chk("t5_pany", 32'(w_pany), 1);
    chk("t5_drop", 32'(w_drop), 0);

    // Asynchronous reset while a word is held and ch4..7 are pending
    do_reset();
    aer_ready = 1'b0;
    repeat (2) tick();
    spike_in = 16'h0001; tick();
    spike_in = 16'h00F0; tick();
    spike_in = '0;
    chk("t6_pre_valid", 32'(aer_valid), 1);
    chk("t6_pre_word", 32'(aer_word), 32'h000002);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_word", 32'(aer_word), 0);
    chk("t6_rst_valid", 32'(aer_valid), 0);
    chk("t6_rst_pany", 32'(pending_any), 0);
    chk("t6_rst_drop", 32'(drop_count), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1; aer_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t6_after_valid_%0d", i), 32'(aer_valid), 0);
      chk($sformatf("t6_after_pany_%0d", i), 32'(pending_any), 0);
      tick();
    end

    // Random traffic against the reference model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      case ((c / 300) % 3)
        0: spike_in = 16'($urandom & $urandom & $urandom);
        1: spike_in = 16'($urandom);
        default: spike_in = 16'($urandom & $urandom & $urandom & $urandom);
      endcase
      arb_en = ($urandom_range(0, 7) != 0);
      aer_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    spike_in = '0; arb_en = 1'b1; aer_ready = 1'b1;
    repeat (40) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
